// File: rtl/pong_score.sv
// pong_score: two-player 2-digit BCD scoreboard with PLAY/OVER game-end FSM.
// Optional SCORE_EDGE_DET_EN: qualify point inputs on rising edges only.
module pong_score #(
  parameter int WIN_SCORE = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       point_l,
  input  logic       point_r,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       score_tick
);
  typedef enum logic {PLAY, OVER} state_t;
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  state_t     r_state, w_next;
  logic [7:0] r_l, r_r, w_nl, w_nr;
  logic [1:0] r_winner, w_winner;
  logic       r_tick, w_pl, w_pr, w_en_l, w_en_r, w_win_l, w_win_r;
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    return s == 8'h99 ? s : s[3:0] == 4'd9 ? {s[7:4] + 4'd1, 4'd0} : {s[7:4], s[3:0] + 4'd1};
  endfunction
`ifdef SCORE_EDGE_DET_EN
  logic r_prev_l, r_prev_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_prev_l <= 1'b0;
      r_prev_r <= 1'b0;
    end else begin
      r_prev_l <= point_l;
      r_prev_r <= point_r;
    end
  assign w_pl = point_l & ~r_prev_l;
  assign w_pr = point_r & ~r_prev_r;
`else
  assign w_pl = point_l;
  assign w_pr = point_r;
`endif
  always_comb begin
    w_en_l   = w_pl && r_state == PLAY && r_l != 8'h99;
    w_en_r   = w_pr && r_state == PLAY && r_r != 8'h99;
    w_nl     = w_en_l ? bcd_inc(r_l) : r_l;
    w_nr     = w_en_r ? bcd_inc(r_r) : r_r;
    w_win_l  = w_nl == WIN_BCD;
    w_win_r  = w_nr == WIN_BCD;
    w_next   = clr ? PLAY : (r_state == PLAY && (w_win_l || w_win_r)) ? OVER : r_state;
    w_winner = clr ? 2'b00 : (r_state == PLAY && w_next == OVER) ? {w_win_r, w_win_l} : r_winner;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= PLAY;
      r_l      <= 8'h00;
      r_r      <= 8'h00;
      r_winner <= 2'b00;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_winner <= w_winner;
      r_l      <= clr ? 8'h00 : w_nl;
      r_r      <= clr ? 8'h00 : w_nr;
      r_tick   <= !clr && (w_en_l || w_en_r);
    end
  assign {dig3, dig2} = r_l;
  assign {dig1, dig0} = r_r;
  assign game_over    = r_state == OVER;
  assign winner       = r_winner;
  assign score_tick   = r_tick;
endmodule

// File: tb/tb_pong_score.sv
// tb_pong_score: directed checks of pong_score at WIN_SCORE=99 (u_a) and 11 (u_b).
module tb_pong_score;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, point_l = 1'b0, point_r = 1'b0;
  logic [3:0] a3, a2, a1, a0, b3, b2, b1, b0;
  logic       a_go, b_go, a_tk, b_tk;
  logic [1:0] a_w, b_w;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  pong_score #(.WIN_SCORE(99)) u_a (.clk(clk), .reset(reset), .clr(clr), .point_l(point_l), .point_r(point_r),
    .dig3(a3), .dig2(a2), .dig1(a1), .dig0(a0), .game_over(a_go), .winner(a_w), .score_tick(a_tk));
  pong_score #(.WIN_SCORE(11)) u_b (.clk(clk), .reset(reset), .clr(clr), .point_l(point_l), .point_r(point_r),
    .dig3(b3), .dig2(b2), .dig1(b1), .dig0(b0), .game_over(b_go), .winner(b_w), .score_tick(b_tk));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic l, input logic r, input logic c);
    point_l = l;
    point_r = r;
    clr = c;
    @(negedge clk);
  endtask
  task automatic pt(input logic l, input logic r);
    step(l, r, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    #7;
    chk("rst_a_dig", {a3, a2, a1, a0}, 16'h0000);
    chk("rst_a_flags", {a_go, a_w, a_tk}, 4'b0000);
    chk("rst_b_flags", {b_go, b_w, b_tk}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("a_tick", a_tk, 1'b1);
      chk("a_bcd_ok", 32'(a3 <= 4'd9 && a2 <= 4'd9), 1);
      if (i == 9) chk("a_carry_09_10", {a3, a2}, 8'h10);
      if (i == 10) chk("b_left_win", {b_go, b_w}, 3'b101);
      if (i == 11) chk("b_over_no_tick", b_tk, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("a_12_left", {a3, a2, a1, a0}, 16'h1200);
    chk("a_not_over", a_go, 1'b0);
    chk("b_hold_11_00", {b3, b2, b1, b0}, 16'h1100);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_a", {a3, a2, a1, a0, a_tk}, 17'h0);
    chk("clr_b", {b3, b2, b1, b0, b_go, b_w, b_tk}, 20'h0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 10) chk("b_right_win", {b_go, b_w, b_tk}, 4'b1101);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("b_over_ign_l", b_tk, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pt(1'b0, 1'b1);
    chk("b_hold_00_11", {b3, b2, b1, b0, b_go, b_w}, {16'h0011, 3'b110});
    chk("a_01_12", {a3, a2, a1, a0}, 16'h0112);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_over_b", {b3, b2, b1, b0, b_go, b_w}, 19'h0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) pt(1'b1, 1'b1);
    chk("b_10_10", {b3, b2, b1, b0, b_go}, {16'h1010, 1'b0});
    step(1'b1, 1'b1, 1'b0);
    chk("b_tie", {b3, b2, b1, b0, b_go, b_w, b_tk}, {16'h1111, 4'b1111});
    chk("a_11_11", {a3, a2, a1, a0, a_tk}, {16'h1111, 1'b1});
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pt(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pt(1'b0, 1'b1);
    chk("a_05_03", {a3, a2, a1, a0}, 16'h0503);
    step(1'b1, 1'b0, 1'b1);
    chk("clr_prio_a", {a3, a2, a1, a0, a_tk}, 17'h0);
    chk("clr_prio_b", {b3, b2, b1, b0, b_tk}, 17'h0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pt(1'b1, 1'b0);
    chk("a_03_00", {a3, a2, a1, a0}, 16'h0300);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_a", {a3, a2, a1, a0, a_go, a_w, a_tk}, 20'h0);
    chk("async_rst_b", {b3, b2, b1, b0}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
`ifdef SCORE_EDGE_DET_EN
    chk("held_tick", a_tk, 1'b0);
`else
    chk("held_tick", a_tk, 1'b1);
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
`ifdef SCORE_EDGE_DET_EN
    chk("held_5", {a3, a2, a1, a0}, 16'h0100);
`else
    chk("held_5", {a3, a2, a1, a0}, 16'h0500);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
